line_reverse_buffer: RTL and testbench

//  Ping-pong row buffer that accepts pixels left-to-right and emits each completed
//  row right-to-left, one word per clken cycle.

---
 rtl/lrb_pkg.sv | 16 +
 rtl/line_reverse_bank.sv | 34 +++
 rtl/sram_1936x54_dp_bit_en.sv | 34 +++
 rtl/line_reverse_buffer.sv | 131 +++++++++++++
 tb/tb_line_reverse_buffer.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/lrb_pkg.sv
// Shared definitions for the line reverse buffer: controller states and
// default geometry of the row banks.
package lrb_pkg;

    localparam int LRB_DWIDTH = 54;
    localparam int LRB_AWIDTH = 11;
    localparam int LRB_DEPTH  = 1936;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } lrb_state_t;

endpackage

// File: rtl/line_reverse_bank.sv
// One row bank: wraps a single SRAM macro with active-high write/read strobes.
module line_reverse_bank
    import lrb_pkg::*;
#(
    parameter int DWIDTH = LRB_DWIDTH,
    parameter int AWIDTH = LRB_AWIDTH,
    parameter int DEPTH  = LRB_DEPTH
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [DWIDTH-1:0] rd_data
);

    sram_1936x54_dp_bit_en #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH),
        .DEPTH  (DEPTH)
    ) u_sram (
        .clk   (clk),
        .cena  (~wr_en),
        .wena  (~wr_en),
        .bwena ({DWIDTH{1'b0}}),
        .aa    (wr_addr),
        .da    (wr_data),
        .cenb  (~rd_en),
        .ab    (rd_addr),
        .qb    (rd_data)
    );

endmodule

// File: rtl/sram_1936x54_dp_bit_en.sv
// Behavioural model of the dual-port row SRAM macro: port A writes, port B reads.
// Chip enable, write enable and bit enables are active-low.
module sram_1936x54_dp_bit_en #(
    parameter int DWIDTH = 54,
    parameter int AWIDTH = 11,
    parameter int DEPTH  = 1936
) (
    input  logic              clk,
    input  logic              cena,
    input  logic              wena,
    input  logic [DWIDTH-1:0] bwena,
    input  logic [AWIDTH-1:0] aa,
    input  logic [DWIDTH-1:0] da,
    input  logic              cenb,
    input  logic [AWIDTH-1:0] ab,
    output logic [DWIDTH-1:0] qb
);

    logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!cena && !wena) begin
            mem[aa] <= (mem[aa] & bwena) | (da & ~bwena);
        end
    end

    // The read port holds its last word while deselected.
    always_ff @(posedge clk) begin
        if (!cenb) begin
            qb <= mem[ab];
        end
    end

endmodule

// File: rtl/line_reverse_buffer.sv
// Ping-pong row buffer: rows are written left-to-right into one bank while the
// previously completed row is read back right-to-left from the other.
module line_reverse_buffer
    import lrb_pkg::*;
#(
    parameter int DWIDTH = LRB_DWIDTH,
    parameter int AWIDTH = LRB_AWIDTH,
    parameter int DEPTH  = LRB_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clken,
    input  logic [AWIDTH-1:0] width,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] din,
    input  logic              flush,
    output logic [DWIDTH-1:0] dout,
    output logic              out_valid,
    output logic              out_last,
    output logic              busy,
    output logic              err
);

    lrb_state_t        state, state_nxt;
    logic [AWIDTH-1:0] wr_ptr, rd_ptr, w_last;
    logic [AWIDTH-1:0] width_last, cur_last;
    logic              wr_bank, rd_bank, out_bank, rd_active;
    logic              accept, row_done, err_set;
    logic [DWIDTH-1:0] bank_q [2];

    // Width 0 behaves as a single column; oversize rows are clipped to the bank.
    always_comb begin
        if (width == '0) begin
            width_last = '0;
        end else if (width > AWIDTH'(DEPTH)) begin
            width_last = AWIDTH'(DEPTH - 1);
        end else begin
            width_last = width - 1'b1;
        end
    end

    assign accept   = clken && in_valid && !flush && (state != DRAIN);
    assign cur_last = (state == IDLE) ? width_last : w_last;
    assign row_done = accept && (wr_ptr == cur_last);
    assign err_set  = clken && ((flush && (state == FILL || (state == STREAM && wr_ptr != '0)))
                             || (flush && in_valid && state != DRAIN)
                             || (in_valid && state == DRAIN));

    always_comb begin
        state_nxt = state;
        if (clken) begin
            case (state)
                IDLE:    if (accept) state_nxt = row_done ? STREAM : FILL;
                FILL:    if (row_done) state_nxt = STREAM;
                STREAM:  if (flush && wr_ptr == '0) state_nxt = DRAIN;
                DRAIN:   if (!rd_active || rd_ptr == '0) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A freshly completed row reloads the read side even while the previous
    // row is finishing its column-0 read in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            rd_ptr    <= '0;
            rd_active <= 1'b0;
            w_last    <= '0;
            out_bank  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            err       <= 1'b0;
        end else if (clken) begin
            state <= state_nxt;
            if (state == IDLE && accept) begin
                w_last <= width_last;
            end
            if (accept) begin
                if (row_done) begin
                    wr_ptr  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end
            if (row_done) begin
                rd_bank   <= wr_bank;
                rd_ptr    <= cur_last;
                rd_active <= 1'b1;
            end else if (rd_active) begin
                if (rd_ptr == '0) begin
                    rd_active <= 1'b0;
                end else begin
                    rd_ptr <= rd_ptr - 1'b1;
                end
            end
            if (rd_active) begin
                out_bank <= rd_bank;
            end
            out_valid <= rd_active;
            out_last  <= rd_active && (rd_ptr == '0);
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        line_reverse_bank #(
            .DWIDTH (DWIDTH),
            .AWIDTH (AWIDTH),
            .DEPTH  (DEPTH)
        ) u_bank (
            .clk     (clk),
            .wr_en   (accept && (wr_bank == 1'(b))),
            .wr_addr (wr_ptr),
            .wr_data (din),
            .rd_en   (clken && rd_active && (rd_bank == 1'(b))),
            .rd_addr (rd_ptr),
            .rd_data (bank_q[b])
        );
    end

    assign dout = out_bank ? bank_q[1] : bank_q[0];
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_line_reverse_buffer.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a row-level reference model with a per-cycle output schedule.
module tb_line_reverse_buffer;
    import lrb_pkg::*;

    localparam int DW = LRB_DWIDTH;
    localparam int AW = LRB_AWIDTH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clken = 1'b1;
    logic [AW-1:0] width = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] din = '0;
    logic          flush = 1'b0;
    logic [DW-1:0] dout;
    logic          out_valid, out_last, busy, err;

    line_reverse_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .clken     (clken),
        .width     (width),
        .in_valid  (in_valid),
        .din       (din),
        .flush     (flush),
        .dout      (dout),
        .out_valid (out_valid),
        .out_last  (out_last),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef enum {M_IDLE, M_FILL, M_STREAM, M_DRAIN} mode_t;
    typedef struct {
        int            cyc;
        logic [DW-1:0] d;
        bit            last;
    } item_t;

    item_t         sched[$];
    logic [DW-1:0] row[$];
    mode_t         mode = M_IDLE;
    int            cyc = 0;
    int            last_out = 0;
    int            w_m = 1;
    bit            err_m = 1'b0;
    bit            e_valid = 1'b0;
    bit            e_last = 1'b0;
    logic [DW-1:0] e_dout = '0;

    int compared = 0;
    int mismatched = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Drive one cycle, advance the reference model with what the DUT sampled,
    // then compare all outputs just after the edge.
    task automatic applyStimulus(input logic r, input logic ce, input logic v, input logic f,
                                 input logic [AW-1:0] w, input logic [DW-1:0] d);
        mode_t nxt;
        item_t it;
        rst = r; clken = ce; in_valid = v; flush = f; width = w; din = d;
        @(posedge clk);
        #1;
        if (r) begin
            mode = M_IDLE;
            row.delete();
            sched.delete();
            err_m = 1'b0;
        end else if (ce) begin
            cyc++;
            nxt = mode;
            if (f) begin
                if (mode == M_FILL || (mode == M_STREAM && row.size() != 0)) err_m = 1'b1;
                if (v && mode != M_DRAIN) err_m = 1'b1;
                if (mode == M_STREAM && row.size() == 0) nxt = M_DRAIN;
            end else if (v) begin
                if (mode == M_DRAIN) begin
                    err_m = 1'b1;
                end else begin
                    if (mode == M_IDLE) begin
                        w_m = (w == 0) ? 1 : ((int'(w) > LRB_DEPTH) ? LRB_DEPTH : int'(w));
                        nxt = M_FILL;
                    end
                    row.push_back(d);
                    if (row.size() == w_m) begin
                        for (int j = 1; j <= w_m; j++) begin
                            it.cyc  = cyc + j;
                            it.d    = row[w_m - j];
                            it.last = (j == w_m);
                            sched.push_back(it);
                        end
                        last_out = cyc + w_m;
                        row.delete();
                        nxt = M_STREAM;
                    end
                end
            end
            if (mode == M_DRAIN && cyc >= last_out) nxt = M_IDLE;
            mode = nxt;
        end
        if (r || ce) begin
            while (sched.size() != 0 && sched[0].cyc < cyc) sched.delete(0);
            if (!r && sched.size() != 0 && sched[0].cyc == cyc) begin
                e_valid = 1'b1;
                e_last  = sched[0].last;
                e_dout  = sched[0].d;
                sched.delete(0);
            end else begin
                e_valid = 1'b0;
                e_last  = 1'b0;
            end
        end
        checkOutput("out_valid", 64'(out_valid), 64'(e_valid));
        checkOutput("out_last", 64'(out_last), 64'(e_last));
        checkOutput("busy", 64'(busy), 64'(mode != M_IDLE));
        checkOutput("err", 64'(err), 64'(err_m));
        if (e_valid) checkOutput("dout", 64'(dout), 64'(e_dout));
    endtask

    task automatic idleCycles(input int n, input logic [AW-1:0] w);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, w, DW'($urandom));
    endtask

    task automatic resetCycles(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), AW'($urandom), {$urandom, $urandom});
    endtask

    logic [AW-1:0] wlist [6] = '{11'd0, 11'd1, 11'd2, 11'd3, 11'd5, 11'd7};

    initial begin
        $display("[TB] scenario 1: reset with random inputs");
        resetCycles(2);

        $display("[TB] scenario 2: width 4, two rows, flush at boundary");
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 11'd4, DW'(i));
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 11'd4, '0);
        idleCycles(6, 11'd4);

        $display("[TB] scenario 3: same traffic with clken low every other cycle");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 11'd4, DW'(i));
            applyStimulus(1'b0, 1'b0, 1'($urandom), 1'b0, 11'd4, {$urandom, $urandom});
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 11'd4, '0);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'(i % 2), 1'b0, 1'b0, 11'd4, '0);

        $display("[TB] scenario 4: width 5 with a gap inside the second row");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 11'd5, DW'(i));
            if (i == 7) idleCycles(3, 11'd5);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 11'd5, '0);
        idleCycles(8, 11'd5);

        $display("[TB] scenario 5: flush mid-row, then flush at boundary");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 11'd4, DW'(100 + i));
            if (i == 1 || i == 5) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 11'd4, '0);
        end
        for (int i = 6; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 11'd4, DW'(100 + i));
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 11'd4, '0);
        idleCycles(6, 11'd4);

        $display("[TB] scenario 6: reset mid-row, then width 1");
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 11'd4, DW'(200 + i));
        resetCycles(1);
        idleCycles(6, 11'd1);
        for (int i = 10; i < 13; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 11'd1, DW'(i));
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 11'd1, '0);
        idleCycles(4, 11'd1);

        $display("[TB] random traffic");
        resetCycles(1);
        for (int i = 0; i < 4000; i++) begin
            applyStimulus(1'($urandom_range(0, 299) == 0),
                          1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 2) != 0),
                          1'($urandom_range(0, 19) == 0),
                          wlist[$urandom_range(0, 5)],
                          {$urandom, $urandom});
        end
        idleCycles(10, 11'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
